// File: rtl/vote_pkg.sv
// Shared voting types and helpers: session states plus popcount / one-hot helpers
// used by the session controller and the counter/display logic.
package vote_pkg;

  localparam int NUM_CAND_DEF = 4;
  localparam int MAX_CAND     = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    COMMIT  = 2'd2,
    LOCKOUT = 2'd3
  } state_e;

  function automatic int unsigned popcount(input logic [MAX_CAND-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_CAND; i++) n += int'(v[i]);
    return n;
  endfunction

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int unsigned first_set(input logic [MAX_CAND-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = MAX_CAND - 1; i >= 0; i--) if (v[i]) idx = i;
    return idx;
  endfunction

  function automatic logic [MAX_CAND-1:0] onehot(input int unsigned idx);
    logic [MAX_CAND-1:0] r;
    r = '0;
    r[idx[4:0]] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/ballot_session_ctrl.sv
// Per-voter ballot session FSM: arms on officer grant, accepts one press, emits a
// one-hot vote strobe, then locks out inputs; spoiled/timed-out/aborted ballots cast nothing.
module ballot_session_ctrl
  import vote_pkg::*;
#(
  parameter int NUM_CAND       = NUM_CAND_DEF,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic                ballot_grant,
  input  logic [NUM_CAND-1:0] cand_pulse,
  output logic [NUM_CAND-1:0] vote_strobe,
  output logic                valid_vote,
  output logic                spoiled,
  output logic                timeout,
  output logic                armed,
  output logic                busy,
  output logic [CNT_W-1:0]    ballots_cast
);

  localparam int TMR_MAX = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);

  state_e              state_q;
  logic [TMR_W-1:0]    timer_q;
  logic [NUM_CAND-1:0] vote_strobe_q, strobe_d;
  logic                valid_vote_q, spoiled_q, timeout_q, armed_q, busy_q;
  logic [CNT_W-1:0]    ballots_cast_q;
  int unsigned         press_cnt_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    press_cnt_d = popcount(MAX_CAND'(cand_pulse));
    strobe_d    = NUM_CAND'(onehot(first_set(MAX_CAND'(cand_pulse))));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      vote_strobe_q  <= '0;
      valid_vote_q   <= 1'b0;
      spoiled_q      <= 1'b0;
      timeout_q      <= 1'b0;
      armed_q        <= 1'b0;
      busy_q         <= 1'b0;
      ballots_cast_q <= '0;
    end else begin
      vote_strobe_q <= '0;
      valid_vote_q  <= 1'b0;
      spoiled_q     <= 1'b0;
      timeout_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ballot_grant && !mode) begin
            state_q <= ARMED;
            timer_q <= TIMEOUT_LOAD;
            armed_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ARMED: begin
          // Priority: result-mode abort, spoil, single press, then expiry.
          if (mode) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (press_cnt_d >= 2) begin
            state_q   <= LOCKOUT;
            timer_q   <= LOCKOUT_LOAD;
            spoiled_q <= 1'b1;
            armed_q   <= 1'b0;
          end else if (press_cnt_d == 1) begin
            state_q       <= COMMIT;
            vote_strobe_q <= strobe_d;
            valid_vote_q  <= 1'b1;
            armed_q       <= 1'b0;
            if (ballots_cast_q != '1) ballots_cast_q <= ballots_cast_q + CNT_W'(1);
          end else if (timer_q == '0) begin
            state_q   <= IDLE;
            timeout_q <= 1'b1;
            armed_q   <= 1'b0;
            busy_q    <= 1'b0;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        COMMIT: begin
          state_q <= LOCKOUT;
          timer_q <= LOCKOUT_LOAD;
        end
        LOCKOUT: begin
          if (timer_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          armed_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign vote_strobe  = vote_strobe_q;
  assign valid_vote   = valid_vote_q;
  assign spoiled      = spoiled_q;
  assign timeout      = timeout_q;
  assign armed        = armed_q;
  assign busy         = busy_q;
  assign ballots_cast = ballots_cast_q;

endmodule

// File: tb/tb_ballot_session_ctrl.sv
// Self-checking bench for ballot_session_ctrl: each session is described as a timeline
// of expected output events derived from the session rules, then replayed cycle by cycle.
module tb_ballot_session_ctrl;

  localparam int NC = 4;
  localparam int TO = 8;
  localparam int LK = 16;
  localparam int CW = 2;
  localparam int CAST_MAX = (1 << CW) - 1;

  localparam int K_NONE   = 0;
  localparam int K_SINGLE = 1;
  localparam int K_MULTI  = 2;
  localparam int K_ABORT  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic          grant = 1'b0;
  logic [NC-1:0] cand = '0;
  logic [NC-1:0] strobe;
  logic          valid, spoil, tmo, armed, busy;
  logic [CW-1:0] cast;

  int n_checks = 0;
  int n_pass   = 0;
  int cast_model = 0;

  always #5 clk = ~clk;

  ballot_session_ctrl #(
    .NUM_CAND(NC), .TIMEOUT_CYCLES(TO), .LOCKOUT_CYCLES(LK), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .ballot_grant(grant), .cand_pulse(cand),
    .vote_strobe(strobe), .valid_vote(valid), .spoiled(spoil), .timeout(tmo),
    .armed(armed), .busy(busy), .ballots_cast(cast)
  );

  function automatic int pop(input logic [NC-1:0] v);
    int n = 0;
    for (int i = 0; i < NC; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [NC-1:0] rand_single();
    logic [NC-1:0] v = '0;
    v[$urandom_range(0, NC-1)] = 1'b1;
    return v;
  endfunction

  function automatic logic [NC-1:0] rand_multi();
    logic [NC-1:0] v;
    do v = NC'($urandom); while (pop(v) < 2);
    return v;
  endfunction

  // One ballot session. Cycle 0 presents the grant; the event (press/abort) lands in
  // armed cycle a (cycle 1+a). Expected outputs per cycle come from the session rules.
  task automatic run_session(input bit m0, input int kind, input int a,
                             input logic [NC-1:0] pv, input bit loud, input string tag);
    int c, evk, len, ecast;
    c   = 1 + a;
    evk = (kind == K_NONE) ? TO + 1 : c;
    if (m0) len = 3;
    else case (kind)
      K_NONE:   len = TO + 2;
      K_ABORT:  len = c + 2;
      K_SINGLE: len = c + 3 + LK;
      default:  len = c + 2 + LK;
    endcase
    for (int k = 0; k < len; k++) begin
      logic [NC+4:0] act, exp_v;
      logic [NC-1:0] es;
      bit ea, eb, ev, esp, et, skip_cast;
      ea = 0; eb = 0; ev = 0; esp = 0; et = 0; es = '0; skip_cast = 0;
      ecast = cast_model;
      @(posedge clk); #1;
      if (!m0) begin
        case (kind)
          K_NONE:   begin ea = (k >= 1 && k <= TO); eb = ea; et = (k == TO + 1); end
          K_ABORT:  begin ea = (k >= 1 && k <= c);  eb = ea; end
          K_SINGLE: begin
            ea = (k >= 1 && k <= c);
            eb = (k >= 1 && k <= c + 1 + LK);
            ev = (k == c + 1);
            es = ev ? pv : '0;
            skip_cast = (k == c + 1);
            if (k > c + 1) ecast = (cast_model < CAST_MAX) ? cast_model + 1 : CAST_MAX;
          end
          default: begin
            ea  = (k >= 1 && k <= c);
            eb  = (k >= 1 && k <= c + LK);
            esp = (k == c + 1);
          end
        endcase
      end
      act   = {armed, busy, valid, spoil, tmo, strobe};
      exp_v = {ea, eb, ev, esp, et, es};
      n_checks++;
      if (act !== exp_v)
        $display("FAIL %s cyc%0d outputs{armed,busy,valid,spoil,tmo,strobe} got %b want %b",
                 tag, k, act, exp_v);
      else n_pass++;
      if (!skip_cast) begin
        n_checks++;
        if (cast !== CW'(ecast))
          $display("FAIL %s cyc%0d ballots_cast got %0d want %0d", tag, k, cast, ecast);
        else n_pass++;
      end
      // Stimulus for this cycle.
      if (k == 0) begin
        grant = 1'b1; mode = m0; cand = NC'($urandom);
      end else if (m0) begin
        grant = 1'b0; mode = 1'($urandom); cand = NC'($urandom);
      end else if (k < evk) begin
        grant = 1'($urandom); mode = 1'b0; cand = '0;
      end else if (k == evk && kind == K_ABORT) begin
        grant = 1'($urandom); mode = 1'b1; cand = NC'($urandom);
      end else if (k == evk && kind != K_NONE) begin
        grant = 1'($urandom); mode = 1'b0; cand = pv;
      end else if (eb) begin
        grant = loud ? 1'b1 : 1'($urandom);
        cand  = loud ? NC'(1) : NC'($urandom);
        mode  = 1'($urandom);
      end else begin
        grant = 1'b0; mode = 1'($urandom); cand = NC'($urandom);
      end
    end
    grant = 1'b0; mode = 1'b0; cand = '0;
    if (!m0 && kind == K_SINGLE && cast_model < CAST_MAX) cast_model++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({armed, busy, valid, spoil, tmo, strobe, cast} !== '0)
      $display("FAIL reset_state outputs got %b want 0",
               {armed, busy, valid, spoil, tmo, strobe, cast});
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    cast_model = 0;
    run_session(1'b1, K_NONE, 0, '0, 1'b0, "reset_idle");
  endtask

  task automatic test_basic_vote();
    run_session(1'b0, K_SINGLE, 2, 4'b0100, 1'b0, "basic_vote");
  endtask

  task automatic test_multi_press();
    run_session(1'b0, K_MULTI, 1, 4'b0011, 1'b0, "multi_press");
  endtask

  task automatic test_timeout();
    run_session(1'b0, K_NONE, 0, '0, 1'b0, "timeout");
    run_session(1'b0, K_SINGLE, TO - 1, 4'b1000, 1'b0, "press_at_expiry");
    run_session(1'b0, K_MULTI, TO - 1, 4'b0110, 1'b0, "spoil_at_expiry");
  endtask

  task automatic test_lockout_regrant();
    run_session(1'b0, K_SINGLE, 0, 4'b0010, 1'b1, "lockout_vote");
    run_session(1'b0, K_MULTI, 3, 4'b1111, 1'b1, "lockout_spoil");
    run_session(1'b0, K_SINGLE, 4, 4'b0001, 1'b0, "regrant");
  endtask

  task automatic test_mode();
    run_session(1'b1, K_SINGLE, 0, 4'b0001, 1'b0, "grant_in_result_mode");
    run_session(1'b0, K_ABORT, 2, '0, 1'b0, "abort_armed");
    run_session(1'b0, K_ABORT, 0, '0, 1'b0, "abort_first_cycle");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) run_session(1'b0, K_SINGLE, i, rand_single(), 1'b0, "saturate");
    n_checks++;
    if (cast !== CW'(CAST_MAX)) $display("FAIL saturation ballots_cast got %0d want %0d", cast, CAST_MAX);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int s = 0; s < 40; s++) begin
      int kind = $urandom_range(0, 3);
      int a    = $urandom_range(0, TO - 1);
      bit m0   = ($urandom_range(0, 7) == 0);
      logic [NC-1:0] pv = (kind == K_MULTI) ? rand_multi() : rand_single();
      run_session(m0, kind, a, pv, 1'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid_armed();
    @(posedge clk); #1;
    grant = 1'b1; mode = 1'b0; cand = '0;
    @(posedge clk); #1;
    grant = 1'b0;
    n_checks++;
    if (armed !== 1'b1) $display("FAIL rst_mid_armed armed got %b want 1", armed);
    else n_pass++;
    @(posedge clk); #1;
    cand = 4'b0010;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({armed, busy, valid, spoil, tmo, strobe, cast} !== '0)
      $display("FAIL rst_mid_armed outputs got %b want 0",
               {armed, busy, valid, spoil, tmo, strobe, cast});
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk) begin rst = 1'b1; cand = '0; end
    cast_model = 0;
    run_session(1'b1, K_NONE, 0, '0, 1'b0, "after_rst");
    run_session(1'b0, K_SINGLE, 1, 4'b0001, 1'b0, "vote_after_rst");
  endtask

  initial begin
    test_reset();
    test_basic_vote();
    test_multi_press();
    test_timeout();
    test_lockout_regrant();
    test_mode();
    test_saturation();
    test_random();
    test_reset_mid_armed();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/ballot_session_ctrl.md
Name: ballot_session_ctrl

Overview:
- Per-voter session controller between the button debouncers and the vote counter.
- Arms one ballot when the polling officer grants it, and accepts exactly one valid candidate press.
- Issues a single one-cycle one-hot vote strobe to the counter, then locks out further presses for a fixed window.
- Rejects multi-press (spoiled), timed-out and result-mode ballots.

Parameters:
- NUM_CAND, 4, number of candidate inputs.
- TIMEOUT_CYCLES, 1000, cycles an armed ballot waits for a press before expiring (≥2).
- LOCKOUT_CYCLES, 16, post-ballot cycles during which all inputs are ignored (≥1).
- CNT_W, 8, width of the ballots_cast counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mode  in  1  0 = voting, 1 = result display.
- ballot_grant  in  1  officer pulse that arms one ballot.
- cand_pulse  in  NUM_CAND  debounced one-cycle press pulses, bit i = candidate i+1.
- vote_strobe  out  NUM_CAND  one-hot, one-cycle increment request to the counter.
- valid_vote  out  1  one-cycle pulse, concurrent with vote_strobe.
- spoiled  out  1  one-cycle pulse: multi-press ballot rejected.
- timeout  out  1  one-cycle pulse: armed ballot expired.
- armed  out  1  high while the ballot is awaiting a press.
- busy  out  1  high whenever state is not IDLE.
- ballots_cast  out  CNT_W  saturating count of valid votes since reset.

Behaviour:
- Reset (rst=0, async): state=IDLE, timer=0. All outputs 0, ballots_cast=0. Reset mid-session discards the ballot with no strobe.
- All outputs are registered. Pulses last exactly one cycle.
- State IDLE:
  - armed=0, busy=0.
  - ballot_grant=1 and mode=0: go to ARMED, timer := TIMEOUT_CYCLES-1.
  - ballot_grant while mode=1: ignored. cand_pulse: ignored.
- State ARMED (armed=1, busy=1). Evaluation priority each cycle:
  1. mode=1: abort to IDLE. No strobe, no spoiled, no timeout.
  2. popcount(cand_pulse)≥2: spoiled pulses next cycle, go to LOCKOUT.
  3. popcount(cand_pulse)==1: latch the index, go to COMMIT.
  4. timer==0: timeout pulses next cycle, go to IDLE.
  5. Otherwise: timer decrements.
  - A press in the same cycle as timer==0 is accepted (the press wins).
  - ballot_grant while ARMED is ignored; it does not re-arm or reload the timer.
- State COMMIT (exactly 1 cycle):
  - vote_strobe=onehot(latched index), valid_vote=1.
  - ballots_cast increments, holding at 2^CNT_W-1.
  - Next state LOCKOUT, timer := LOCKOUT_CYCLES-1.
  - mode changes during COMMIT do not cancel the vote.
- State LOCKOUT:
  - busy=1. All inputs ignored, including ballot_grant and cand_pulse.
  - timer counts down. At timer==0, go to IDLE.
  - After a spoil, the next IDLE arrival is LOCKOUT_CYCLES+1 cycles after the press cycle.
- Latency:
  - Single press sampled in ARMED cycle N: vote_strobe high in cycle N+1, lockout cycles N+2..N+1+LOCKOUT_CYCLES, IDLE from cycle N+2+LOCKOUT_CYCLES.
  - Multi-press in cycle N: spoiled in N+1, LOCKOUT in N+1..N+LOCKOUT_CYCLES, IDLE from N+1+LOCKOUT_CYCLES.
- Guarantees:
  - vote_strobe is never multi-hot.
  - At most one valid_vote per ballot_grant accepted.
- The timer is a single shared down-counter of width clog2(max(TIMEOUT_CYCLES, LOCKOUT_CYCLES)).

Decomposition:
- Shared package vote_pkg:
  - NUM_CAND default.
  - State enum {IDLE, ARMED, COMMIT, LOCKOUT}, 2-bit encoding.
  - popcount and onehot-encode functions, reused by the counter/display logic.
- No sub-module needed; the timer and FSM live in one module.

Test Plan:
- Basic vote: reset; grant with mode=0; 3 cycles later cand_pulse=4'b0100 → vote_strobe=4'b0100 for exactly 1 cycle, valid_vote=1, ballots_cast=1, IDLE reached 18 cycles after the press cycle (N+2+16), with N the press cycle.
- Multi-press: armed, cand_pulse=4'b0011 → spoiled pulse, no vote_strobe, ballots_cast unchanged, busy held for 16 cycles.
- Timeout: TIMEOUT_CYCLES=8, grant, no press → timeout pulses 8 cycles after arming, no vote_strobe. A press on the same cycle as timer==0 → vote accepted, no timeout.
- Lockout/regrant: during LOCKOUT, apply cand_pulse=4'b0001 and ballot_grant → both ignored, no strobe. Grant after IDLE → re-arms normally.
- Mode interplay: grant with mode=1 → stays IDLE. Armed, then mode=1 → back to IDLE, no pulses; a subsequent press yields no strobe.
- Saturation/reset: CNT_W=2, cast 5 ballots → ballots_cast holds at 3. Assert rst low during ARMED → all outputs 0 immediately, no vote.
